// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file and its
// pending-write scoreboard.
package reg_file_pkg;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 0;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// Read/writeback/issue bus between the pipeline core and reg_file_sb.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int DEPTH  = NREGS,
  parameter int NUM_RD = 2
) ();
  localparam int ADDR_W = addr_width(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_sel;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_reg;
  logic [WIDTH-1:0]         wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_reg;
  logic                     flush;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output rd_sel, wr_en, wr_reg, wr_data, issue_en, issue_reg, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_sel, wr_en, wr_reg, wr_data, issue_en, issue_reg, flush,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: busy vector with issue/writeback/flush precedence
// and a registered popcount of the pending registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = NREGS,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_count
);
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  count_nxt;

  // Writeback releases first so a same-edge issue re-claims the register.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en && (wr_reg != ADDR_W'(ZERO_REG))) busy_nxt[wr_reg] = 1'b0;
    if (flush)
      busy_nxt = '0;
    else if (issue_en && (issue_reg != ADDR_W'(ZERO_REG)))
      busy_nxt[issue_reg] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      count_nxt = count_nxt + (ADDR_W + 1)'(busy_nxt[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec   <= '0;
      busy_count <= '0;
    end else begin
      busy_vec   <= busy_nxt;
      busy_count <= count_nxt;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with bypassed combinational read ports,
// hardwired-zero register 0 and a pending-write scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int DEPTH  = NREGS,
  parameter int NUM_RD = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = addr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_vec;
  logic             wr_ok;
  logic             issue_ok;

  assign wr_ok    = bus.wr_en && (bus.wr_reg != ADDR_W'(ZERO_REG));
  assign issue_ok = bus.issue_en && (bus.issue_reg != ADDR_W'(ZERO_REG));

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_reg] <= bus.wr_data;
    end
  end

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (bus.wr_en),
    .wr_reg    (bus.wr_reg),
    .issue_en  (bus.issue_en),
    .issue_reg (bus.issue_reg),
    .flush     (bus.flush),
    .busy_vec  (busy_vec),
    .busy_count(bus.busy_count)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic              hit;
    logic              claim;

    assign sel   = bus.rd_sel[g*ADDR_W +: ADDR_W];
    assign hit   = wr_ok && (bus.wr_reg == sel);
    assign claim = issue_ok && (bus.issue_reg == sel);

    assign bus.rd_data[g*WIDTH +: WIDTH] = hit ? bus.wr_data : mem[sel];
    assign bus.rd_busy[g] = claim | (~hit & busy_vec[sel]);
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus queues expected values, a monitor
// process compares them against the DUT outputs when triggered.
module tb_reg_file_sb;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reg_file_sb_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) ifa ();
  reg_file_sb_if #(.WIDTH(64), .DEPTH(16), .NUM_RD(4)) ifb ();

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifa)
  );

  reg_file_sb #(.WIDTH(64), .DEPTH(16), .NUM_RD(4)) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifb)
  );

  typedef struct {
    string       name;
    int          dut;   // 0 = 32x32x2, 1 = 64x16x4
    int          kind;  // 0 = rd_data, 1 = rd_busy, 2 = busy_count
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;

  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        exp_t        e;
        logic [63:0] act;
        e = q.pop_front();
        act = '0;
        if (e.dut == 0) begin
          case (e.kind)
            0:       act = 64'(ifa.rd_data[e.port*32 +: 32]);
            1:       act = 64'(ifa.rd_busy[e.port]);
            default: act = 64'(ifa.busy_count);
          endcase
        end else begin
          case (e.kind)
            0:       act = ifb.rd_data[e.port*64 +: 64];
            1:       act = 64'(ifb.rd_busy[e.port]);
            default: act = 64'(ifb.busy_count);
          endcase
        end
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input string n, input int dut, input int kind,
                          input int port, input logic [63:0] v);
    exp_t e;
    e.name = n; e.dut = dut; e.kind = kind; e.port = port; e.exp = v;
    q.push_back(e);
  endtask

  task automatic check_now();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic idle_a();
    ifa.wr_en = 1'b0; ifa.wr_reg = '0; ifa.wr_data = '0;
    ifa.issue_en = 1'b0; ifa.issue_reg = '0; ifa.flush = 1'b0;
  endtask

  task automatic idle_b();
    ifb.wr_en = 1'b0; ifb.wr_reg = '0; ifb.wr_data = '0;
    ifb.issue_en = 1'b0; ifb.issue_reg = '0; ifb.flush = 1'b0;
  endtask

  task automatic sel_a(input int s0, input int s1);
    ifa.rd_sel = {5'(s1), 5'(s0)};
  endtask

  function automatic logic [63:0] b_val(input int r);
    return {16'hB0B0, 16'(r), 16'h5A5A, 16'(r * 3)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_a(); idle_b();
    sel_a(0, 0);
    ifb.rd_sel = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Reset state: every register reads 0 and is idle on both ports.
    for (int r = 0; r < 32; r++) begin
      sel_a(r, r);
      expect_v("rst_data_p0", 0, 0, 0, 0);
      expect_v("rst_data_p1", 0, 0, 1, 0);
      expect_v("rst_busy_p0", 0, 1, 0, 0);
      expect_v("rst_busy_p1", 0, 1, 1, 0);
      check_now();
    end
    expect_v("rst_count_a", 0, 2, 0, 0);
    expect_v("rst_count_b", 1, 2, 0, 0);
    check_now();

    // Same-cycle bypass of a write, then the stored read.
    @(negedge clock);
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd7; ifa.wr_data = 32'h12345678;
    sel_a(7, 0);
    expect_v("bypass_r7", 0, 0, 0, 64'h12345678);
    expect_v("bypass_r7_busy", 0, 1, 0, 0);
    check_now();
    @(negedge clock);
    idle_a();
    expect_v("stored_r7", 0, 0, 0, 64'h12345678);
    expect_v("stored_r7_busy", 0, 1, 0, 0);
    check_now();

    // Register 0 ignores writes and issues.
    @(negedge clock);
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd0; ifa.wr_data = 32'hFFFFFFFF;
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd0;
    sel_a(0, 0);
    expect_v("r0_bypass", 0, 0, 0, 0);
    expect_v("r0_busy_now", 0, 1, 0, 0);
    check_now();
    @(negedge clock);
    idle_a();
    expect_v("r0_stored", 0, 0, 1, 0);
    expect_v("r0_busy", 0, 1, 1, 0);
    expect_v("r0_count", 0, 2, 0, 0);
    check_now();

    // Issue reg 3; same-cycle issue shows busy immediately.
    @(negedge clock);
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd3;
    sel_a(0, 3);
    expect_v("issue3_busy_now", 0, 1, 1, 1);
    check_now();
    @(negedge clock);
    idle_a();
    expect_v("issue3_busy", 0, 1, 1, 1);
    expect_v("issue3_count", 0, 2, 0, 1);
    check_now();

    // Writeback and re-issue of reg 3 on the same edge: new owner wins.
    @(negedge clock);
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd3; ifa.wr_data = 32'h00000033;
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd3;
    sel_a(3, 3);
    expect_v("wbiss3_data_now", 0, 0, 0, 64'h33);
    expect_v("wbiss3_busy_now", 0, 1, 0, 1);
    check_now();
    @(negedge clock);
    idle_a();
    expect_v("wbiss3_data", 0, 0, 0, 64'h33);
    expect_v("wbiss3_busy", 0, 1, 0, 1);
    expect_v("wbiss3_count", 0, 2, 0, 1);
    check_now();

    // Release reg 3 while issuing 1, then issue 2 and 4.
    @(negedge clock);
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd3; ifa.wr_data = 32'h00000044;
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd1;
    sel_a(3, 1);
    expect_v("wb3_bypass_busy", 0, 1, 0, 0);
    check_now();
    @(negedge clock);
    idle_a();
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd2;
    @(negedge clock);
    ifa.issue_reg = 5'd4;
    @(negedge clock);
    idle_a();
    sel_a(3, 4);
    expect_v("three_count", 0, 2, 0, 3);
    expect_v("r3_released", 0, 1, 0, 0);
    expect_v("r3_data", 0, 0, 0, 64'h44);
    expect_v("r4_busy", 0, 1, 1, 1);
    check_now();

    // Flush drops the concurrent issue but keeps the writeback data.
    @(negedge clock);
    ifa.flush = 1'b1;
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd6;
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd2; ifa.wr_data = 32'h000000A5;
    @(negedge clock);
    idle_a();
    sel_a(2, 6);
    expect_v("flush_r2_data", 0, 0, 0, 64'hA5);
    expect_v("flush_r2_busy", 0, 1, 0, 0);
    expect_v("flush_r6_busy", 0, 1, 1, 0);
    expect_v("flush_count", 0, 2, 0, 0);
    check_now();
    sel_a(1, 4);
    expect_v("flush_r1_busy", 0, 1, 0, 0);
    expect_v("flush_r4_busy", 0, 1, 1, 0);
    check_now();

    // Asynchronous reset mid-run clears data and scoreboard at once.
    @(negedge clock);
    ifa.wr_en = 1'b1; ifa.wr_reg = 5'd5; ifa.wr_data = 32'hDEADBEEF;
    @(negedge clock);
    idle_a();
    ifa.issue_en = 1'b1; ifa.issue_reg = 5'd8;
    @(negedge clock);
    idle_a();
    sel_a(5, 8);
    expect_v("pre_rst_r5", 0, 0, 0, 64'hDEADBEEF);
    expect_v("pre_rst_r8_busy", 0, 1, 1, 1);
    expect_v("pre_rst_count", 0, 2, 0, 1);
    check_now();
    reset_n = 1'b0;
    expect_v("async_rst_r5", 0, 0, 0, 0);
    expect_v("async_rst_r8_busy", 0, 1, 1, 0);
    expect_v("async_rst_count", 0, 2, 0, 0);
    check_now();
    @(negedge clock);
    reset_n = 1'b1;

    // Wide variant: four ports read distinct registers.
    for (int r = 1; r <= 4; r++) begin
      @(negedge clock);
      ifb.wr_en = 1'b1; ifb.wr_reg = 4'(r); ifb.wr_data = b_val(r);
    end
    @(negedge clock);
    idle_b();
    ifb.rd_sel = {4'd1, 4'd2, 4'd3, 4'd4};
    expect_v("b_p0_r4", 1, 0, 0, b_val(4));
    expect_v("b_p1_r3", 1, 0, 1, b_val(3));
    expect_v("b_p2_r2", 1, 0, 2, b_val(2));
    expect_v("b_p3_r1", 1, 0, 3, b_val(1));
    check_now();

    // Bypass on every port simultaneously, plus a mixed selection.
    @(negedge clock);
    ifb.wr_en = 1'b1; ifb.wr_reg = 4'd9; ifb.wr_data = 64'hCAFEF00D00000009;
    ifb.rd_sel = {4'd9, 4'd9, 4'd9, 4'd9};
    for (int p = 0; p < 4; p++) begin
      expect_v("b_bypass_all", 1, 0, p, 64'hCAFEF00D00000009);
    end
    check_now();
    ifb.rd_sel = {4'd2, 4'd9, 4'd15, 4'd9};
    expect_v("b_mix_p0", 1, 0, 0, 64'hCAFEF00D00000009);
    expect_v("b_mix_p1", 1, 0, 1, 0);
    expect_v("b_mix_p2", 1, 0, 2, 64'hCAFEF00D00000009);
    expect_v("b_mix_p3", 1, 0, 3, b_val(2));
    check_now();
    @(negedge clock);
    idle_b();
    ifb.issue_en = 1'b1; ifb.issue_reg = 4'd15;
    @(negedge clock);
    idle_b();
    ifb.rd_sel = {4'd15, 4'd9, 4'd15, 4'd0};
    expect_v("b_stored_r9", 1, 0, 2, 64'hCAFEF00D00000009);
    expect_v("b_busy_r15_p1", 1, 1, 1, 1);
    expect_v("b_busy_r15_p3", 1, 1, 3, 1);
    expect_v("b_busy_r0", 1, 1, 0, 0);
    expect_v("b_count", 1, 2, 0, 1);
    check_now();

    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the single-cycle CPU's 32x32 register file. Provides NUM_RD combinational read ports with write-to-read bypass, a synchronous writeback port, a hardwired-zero register 0, asynchronous clear of all contents, and a per-register pending-write scoreboard. The pipelined core uses the scoreboard in decode for hazard stalls and in writeback for release.

## Interface
Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, at least 2.
- NUM_RD, 2, number of read ports; 1 to 4.
- ADDR_W, $clog2(DEPTH), register select width; derived, not overridden.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_sel  in  NUM_RD*ADDR_W  read selects; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WIDTH  read data, packed the same way as rd_sel.
- rd_busy  out  NUM_RD  per read port: the selected register has a write pending.
- wr_en  in  1  writeback enable.
- wr_reg  in  ADDR_W  writeback destination.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  mark issue_reg as pending.
- issue_reg  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  clear all pending bits.
- busy_count  out  ADDR_W+1  number of registers currently pending.

## Operation
- Storage: DEPTH registers of WIDTH bits plus a DEPTH-bit busy vector.
- Reset (reset_n low, any time, including mid-operation):
  - all registers and all busy bits clear to 0 immediately;
  - rd_data then reflects 0 and rd_busy is 0;
  - busy_count is 0.
- Register 0:
  - always reads 0 and is never busy;
  - writes and issues to register 0 are ignored.
- Read port i (combinational):
  - if wr_en is high, wr_reg equals rd_sel[i], and wr_reg is nonzero: rd_data[i] = wr_data (bypass) and rd_busy[i] = 0;
  - otherwise rd_data[i] = the stored value and rd_busy[i] = the stored busy bit;
  - exception: if issue_en targets the same register in that cycle, rd_busy[i] = 1.
  - Bypass and busy logic apply to every read port independently. Ports selecting the same register return identical values.
- Writeback: on the clock edge with wr_en high and wr_reg nonzero, store wr_data and clear busy[wr_reg]. Writeback to a register that is not busy is legal: data is stored and busy stays 0.
- Issue: on the clock edge with issue_en high, issue_reg nonzero and flush low, set busy[issue_reg].
- Precedence when events coincide on the same register:
  - issue and writeback together: data is written and busy ends at 1 (the new owner wins);
  - issue of an already-busy register: busy stays 1 (no counting of multiple owners).
- Flush: on the clock edge, clear every busy bit and drop any issue in the same cycle. A writeback in the same cycle still stores its data.
- busy_count: registered popcount of the busy vector, updated on the same edge as the busy vector. The maximum value is DEPTH-1.

## Timing
- Read path: zero latency, combinational from rd_sel, wr_*, issue_* and the stored state.
- Write, issue and flush: take effect at the next rising clock edge and are visible to non-bypassed reads in the following cycle.
- busy_count matches the busy vector at the same edge; there is no extra lag.
- Reset assertion is asynchronous. Deassertion is assumed synchronised upstream; the first edge after release may carry a write.

## Structure
- Shared package reg_file_pkg holds:
  - default constants XLEN = 32, NREGS = 32;
  - the zero-register index constant;
  - the function used to derive ADDR_W.
- Natural sub-module: reg_scoreboard. It contains the busy vector, the issue/writeback/flush precedence logic and the busy_count popcount register. reg_file_sb instantiates it alongside the data array and the read muxes.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset, then read all registers on both ports -> every rd_data = 0, rd_busy = 0, busy_count = 0. Assert reset_n low mid-run after writing reg 5 = 0xDEADBEEF -> reg 5 reads 0 immediately.
- Write reg 7 = 0x12345678 while rd_sel[0] = 7 in the same cycle -> rd_data[0] = 0x12345678 combinationally; next cycle a stored read also returns 0x12345678.
- Write reg 0 = 0xFFFFFFFF with issue_reg = 0 -> reg 0 reads 0, rd_busy = 0, busy_count unchanged.
- Issue reg 3, then wait a cycle -> rd_busy = 1 and busy_count = 1. Then writeback reg 3 and issue reg 3 in the same cycle -> data updated, busy stays 1, busy_count = 1.
- Issue regs 1, 2 and 4 -> busy_count = 3. Then flush together with issue reg 6 and writeback reg 2 = 0xA5 -> all busy bits 0, busy_count = 0, reg 2 = 0xA5.
- Build with NUM_RD = 4, WIDTH = 64, DEPTH = 16: all four ports read distinct registers correctly, and the bypass works on each port.
